img_stream_loader: RTL and testbench
====================================

# img_stream_loader

Front-end loader that sits directly upstream of the atrous-convolution engine. It accepts a raster-order pixel stream with a valid/ready handshake and writes each frame into the 64×64 image memory. It then raises `ready` to hand the frame to the engine and holds off the next frame until the engine drops `busy`. Pixels are 13-bit signed fixed-point, 4 fractional bits; the loader stores them unchanged.

## Interface
Parameters:
- `IMG_W`, 64: pixels per row (power of two).
- `IMG_H`, 64: rows per frame.
- `DW`, 13: pixel width.
- `AW`, 12: image memory address width, log2(IMG_W*IMG_H).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `s_valid` in 1: stream beat valid.
- `s_ready` out 1: loader can accept a beat.
- `s_data` in DW: signed pixel.
- `s_sof` in 1: beat is pixel (0,0) of a frame.
- `img_we` out 1: image memory write enable.
- `img_addr` out AW: write address, row*IMG_W+col.
- `img_wdata` out DW: write data.
- `ready` out 1: frame loaded; goes to the engine's `ready` input.
- `busy` in 1: engine busy; driven by the engine's `busy` output.
- `frame_err` out 1: one-cycle pulse on a stream protocol error.
- `frame_cnt` out 8: completed frames, wraps 255→0.

## Operation
- A beat is accepted when `s_valid && s_ready` at a rising edge.
- States:
  - IDLE: `s_ready`=1.
    - Accepted beat with `s_sof`=1: write addr 0, pixel counter := 1, go to LOAD.
    - Accepted beat with `s_sof`=0: discard it, pulse `frame_err`.
  - LOAD: `s_ready`=1. Each accepted beat writes at pixel counter, then the counter increments.
    - Accepted beat with `s_sof`=1: frame restart. Pulse `frame_err`, write addr 0, counter := 1, stay in LOAD.
    - Accepted beat at counter IMG_W*IMG_H-1 (4095): go to HANDOFF.
  - HANDOFF: `s_ready`=0, `ready`=1. When `busy`=1 is sampled, deassert `ready` and go to WAIT_DONE.
  - WAIT_DONE: `s_ready`=0, `ready`=0. When `busy`=0 is sampled, `frame_cnt`++ and go to IDLE.
- Data is written verbatim, with no sign or format change.
- The address is the concatenation row[5:0], col[5:0]. The counter wraps only through the state change; it never writes past 4095.
- Pixels before the first sof, and a sof arriving while `s_ready`=0, are never written.

## Timing
- Reset values: `s_ready`=0 during reset, then 1 from the first cycle out of reset. `img_we`=0, `img_addr`=0, `img_wdata`=0, `ready`=0, `frame_err`=0, `frame_cnt`=0. State is IDLE.
- Write latency is 1: a beat accepted at edge T gives `img_we`=1 with its addr/data during cycle T..T+1. `img_we` is a single-cycle pulse per beat.
- A full frame at 1 beat/cycle takes 4096 cycles.
- `ready` rises two edges after the last beat is accepted, so the final write is committed first.
- The engine samples `ready` and raises `busy` the next cycle. The loader drops `ready` on the edge after it sees `busy`=1. `ready` must not re-assert during WAIT_DONE.
- `busy` already high on entry to HANDOFF: `ready` still pulses for at least one cycle.
- `frame_err` pulses in the cycle after the offending beat. Back-to-back errors give back-to-back pulses.
- `s_valid` gaps of any length are allowed and do not affect the counter.
- Reset mid-frame or mid-handoff: return to IDLE on the next edge and clear counters. Image memory contents are left undefined and are not cleared.

## Structure
- Shared package `atconv_pkg`: IMG_W, IMG_H, DW, AW, a pixel typedef (signed DW), and the loader state enum (IDLE, LOAD, HANDOFF, WAIT_DONE).
- The engine consumes the same constants.
- One natural sub-module: `raster_addr_cnt`, a row/col counter with load-zero, increment and last-pixel flag. It is reusable by other raster-stage blocks.

## Test plan
- Full frame, ramp data `s_data`=addr[12:0], sof on the first beat, `busy` held 0: 4096 writes with `img_wdata`==`img_addr`. `ready` rises 2 edges after beat 4095.
- Same frame with random 0–3 cycle `s_valid` gaps: identical memory image, `frame_err` never pulses.
- 10 beats with `s_sof`=0, then a normal frame: 10 `frame_err` pulses, none of those beats written, frame loads correctly.
- sof re-asserted at beat 1000: one `frame_err` pulse, write resumes at addr 0, `ready` only after 4096 further beats.
- Handoff: `busy` rises 1 cycle after `ready` and falls 500 cycles later. `ready` drops after 1 cycle, `s_ready` stays 0 throughout, `frame_cnt` becomes 1 and `s_ready`=1 the cycle after `busy` falls.
- `reset` asserted at beat 2000, then a clean frame: all outputs at reset values, the new frame loads from addr 0, `frame_cnt`=0 before completion.

Source files
------------

// File: rtl/atconv_pkg.sv
// rtl/atconv_pkg.sv - shared constants and types for the atrous-convolution image path
package atconv_pkg;

    localparam int IMG_W = 64;
    localparam int IMG_H = 64;
    localparam int DW    = 13;
    localparam int AW    = 12;

    // Signed fixed-point pixel, 4 fractional bits
    typedef logic signed [DW-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HANDOFF,
        ST_WAIT_DONE
    } ld_state_e;

endpackage

// File: rtl/raster_addr_cnt.sv
// rtl/raster_addr_cnt.sv - raster row/col counter with load-zero, increment and last-pixel flag
module raster_addr_cnt #(
    parameter int COL_W  = 6,
    parameter int ROW_W  = 6,
    parameter int N_ROWS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr_i,
    input  logic                   inc_i,
    output logic [ROW_W+COL_W-1:0] addr_o,
    output logic                   last_o
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             col_end;

    assign col_end = &col_q;

    // clr_i together with inc_i lands on pixel 1: pixel 0 is consumed in the same cycle
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            row_d    = '0;
            col_d    = '0;
            col_d[0] = inc_i;
        end else if (inc_i) begin
            col_d = col_q + 1'b1;
            if (col_end) begin
                row_d = row_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign addr_o = {row_q, col_q};
    assign last_o = col_end && (row_q == LAST_ROW);

endmodule

// File: rtl/img_stream_loader.sv
// rtl/img_stream_loader.sv - loads a raster pixel stream into image memory and hands frames to the engine
module img_stream_loader #(
    parameter int IMG_W = atconv_pkg::IMG_W,
    parameter int IMG_H = atconv_pkg::IMG_H,
    parameter int DW    = atconv_pkg::DW,
    parameter int AW    = atconv_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic          s_sof,
    output logic          img_we,
    output logic [AW-1:0] img_addr,
    output logic [DW-1:0] img_wdata,
    output logic          ready,
    input  logic          busy,
    output logic          frame_err,
    output logic [7:0]    frame_cnt
);
    import atconv_pkg::*;

    localparam int CW = $clog2(IMG_W);
    localparam int RW = AW - CW;

    ld_state_e     state_q;
    logic          s_ready_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          ready_q;
    logic          hold_q;
    logic          err_q;
    logic [7:0]    frame_cnt_q;

    logic          accept;
    logic          cnt_clr;
    logic          cnt_inc;
    logic          cnt_last;
    logic [AW-1:0] cnt_addr;

    assign accept = s_valid && s_ready_q;

    always_comb begin
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (accept) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_clr = s_sof;
                    cnt_inc = s_sof;
                end
                ST_LOAD: begin
                    if (s_sof) begin
                        cnt_clr = 1'b1;
                        cnt_inc = 1'b1;
                    end else if (cnt_last) begin
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    raster_addr_cnt #(
        .COL_W  (CW),
        .ROW_W  (RW),
        .N_ROWS (IMG_H)
    ) u_raster_addr_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .addr_o (cnt_addr),
        .last_o (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_ready_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            hold_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            we_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        if (s_sof) begin
                            we_q    <= 1'b1;
                            addr_q  <= '0;
                            wdata_q <= s_data;
                            state_q <= ST_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        we_q    <= 1'b1;
                        wdata_q <= s_data;
                        if (s_sof) begin
                            err_q  <= 1'b1;
                            addr_q <= '0;
                        end else begin
                            addr_q <= cnt_addr;
                            if (cnt_last) begin
                                state_q   <= ST_HANDOFF;
                                s_ready_q <= 1'b0;
                                hold_q    <= 1'b0;
                            end
                        end
                    end
                end
                ST_HANDOFF: begin
                    // One spare cycle lets the last write land before the engine sees ready
                    if (!ready_q) begin
                        hold_q <= 1'b1;
                        if (hold_q) begin
                            ready_q <= 1'b1;
                        end
                    end else if (busy) begin
                        ready_q <= 1'b0;
                        state_q <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!busy) begin
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        state_q     <= ST_IDLE;
                        s_ready_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign s_ready   = s_ready_q;
    assign img_we    = we_q;
    assign img_addr  = addr_q;
    assign img_wdata = wdata_q;
    assign ready     = ready_q;
    assign frame_err = err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_img_stream_loader.sv
// tb/tb_img_stream_loader.sv - scoreboard bench for img_stream_loader
module tb_img_stream_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_sof = 1'b0;
    logic        busy = 1'b0;
    logic [12:0] s_data = '0;
    logic        s_ready;
    logic        img_we;
    logic [11:0] img_addr;
    logic [12:0] img_wdata;
    logic        ready;
    logic        frame_err;
    logic [7:0]  frame_cnt;

    always #5 clk = ~clk;

    img_stream_loader dut (
        .clk       (clk),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_sof     (s_sof),
        .img_we    (img_we),
        .img_addr  (img_addr),
        .img_wdata (img_wdata),
        .ready     (ready),
        .busy      (busy),
        .frame_err (frame_err),
        .frame_cnt (frame_cnt)
    );

    typedef struct packed {
        logic [11:0] a;
        logic [12:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  errs_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (frame_err === 1'b1) errs_seen++;
        if (img_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write", img_addr, img_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {20'd0, img_addr}, {20'd0, e.a});
                check("wr_data", {19'd0, img_wdata}, {19'd0, e.d});
            end
        end
    end

    function automatic logic [12:0] pix(input int mode, input int i);
        logic [12:0] v;
        v = i[12:0];
        return (mode != 0) ? (v ^ 13'h1555) : v;
    endfunction

    task automatic beat(input logic [12:0] d, input logic sof, input bit wr,
                        input logic [11:0] a, input int gap);
        int n;
        n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        if (wr) exp_q.push_back({a, d});
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        while (s_ready !== 1'b1 && n < 64) begin @(posedge clk); #1; n++; end
        check("beat_accept", {31'd0, s_ready}, 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic beats(input int mode, input bit gaps, input int first, input int last, input bit sof_first);
        for (int i = first; i <= last; i++) begin
            beat(pix(mode, i), sof_first && (i == first), 1'b1, i[11:0],
                 gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic ready_rise();
        check("s_ready_handoff", {31'd0, s_ready}, 32'd0);
        check("ready_edge1", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_edge2", {31'd0, ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_rise", {31'd0, ready}, 32'd1);
    endtask

    task automatic handoff(input int hold, input int exp_cnt);
        busy = 1'b1;
        @(posedge clk); #1;
        check("ready_drop", {31'd0, ready}, 32'd0);
        repeat (hold) begin
            check("ready_wait", {31'd0, ready}, 32'd0);
            check("s_ready_wait", {31'd0, s_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("frame_cnt_wait", {24'd0, frame_cnt}, exp_cnt - 1);
        busy = 1'b0;
        @(posedge clk); #1;
        check("frame_cnt_done", {24'd0, frame_cnt}, exp_cnt);
        check("s_ready_done", {31'd0, s_ready}, 32'd1);
        check("ready_done", {31'd0, ready}, 32'd0);
    endtask

    task automatic check_reset_vals();
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_img_we", {31'd0, img_we}, 32'd0);
        check("rst_img_addr", {20'd0, img_addr}, 32'd0);
        check("rst_img_wdata", {19'd0, img_wdata}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'd0);
    endtask

    initial begin
        #800000;
        fails++;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;
        check("s_ready_out_of_reset", {31'd0, s_ready}, 32'd1);

        // Ramp frame, back-to-back beats, long engine busy window
        beats(0, 1'b0, 0, 4095, 1'b1);
        ready_rise();
        handoff(500, 1);
        check("no_err_frame_a", errs_seen, 32'd0);

        // Same frame with random valid gaps
        beats(0, 1'b1, 0, 4095, 1'b1);
        ready_rise();
        handoff(5, 2);
        check("no_err_frame_b", errs_seen, 32'd0);

        // Beats before any sof are dropped and flagged
        for (int i = 0; i < 10; i++) beat(13'h1A00 + 13'(i), 1'b0, 1'b0, 12'h000, 0);
        @(posedge clk); #1;
        check("err_pre_sof", errs_seen, 32'd10);

        // busy already high when the frame completes
        busy = 1'b1;
        beats(1, 1'b0, 0, 4095, 1'b1);
        ready_rise();
        @(posedge clk); #1;
        check("ready_pulse_drop", {31'd0, ready}, 32'd0);
        check("frame_cnt_busy_pre", {24'd0, frame_cnt}, 32'd2);
        busy = 1'b0;
        @(posedge clk); #1;
        check("frame_cnt_c", {24'd0, frame_cnt}, 32'd3);
        check("s_ready_c", {31'd0, s_ready}, 32'd1);

        // sof re-asserted at beat 1000 restarts the frame
        beats(0, 1'b0, 0, 999, 1'b1);
        beats(1, 1'b0, 0, 4094, 1'b1);
        check("err_restart", errs_seen, 32'd11);
        check("ready_before_last", {31'd0, ready}, 32'd0);
        check("s_ready_before_last", {31'd0, s_ready}, 32'd1);
        beats(1, 1'b0, 4095, 4095, 1'b0);
        ready_rise();
        handoff(3, 4);

        // Reset in the middle of a frame, then a clean frame
        beats(0, 1'b0, 0, 1999, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_vals();
        reset = 1'b0;
        @(posedge clk); #1;
        check("s_ready_after_reset", {31'd0, s_ready}, 32'd1);
        beats(1, 1'b0, 0, 4094, 1'b1);
        check("frame_cnt_before_done", {24'd0, frame_cnt}, 32'd0);
        check("ready_before_done", {31'd0, ready}, 32'd0);
        beats(1, 1'b0, 4095, 4095, 1'b0);
        ready_rise();
        handoff(2, 1);

        repeat (3) begin @(posedge clk); #1; end
        check("scoreboard_empty", exp_q.size(), 32'd0);
        check("err_total", errs_seen, 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
